register_pipeline_elastic: RTL and testbench
============================================

// Module: register_pipeline_elastic
// PURPOSE
//   Parametrised, back-pressurable register pipeline for the compression datapath.
//   Extends the plain reset register with N-bit data, DEPTH stages, valid/ready
//   handshake, flush and occupancy reporting.
//   Retimes long routes between the hash/match/encode blocks without stalling
//   streaming at 1 beat/cycle.
//   Every stage is a 2-entry skid buffer, so no ready path is combinational end-to-end.
// PARAMETERS
//   N      32  data width in bits (>=1)
//   DEPTH  2   number of skid stages (>=1); latency and capacity scale with it
// PORTS
//   clk        in   1                      single clock; all state updates on posedge
//   reset      in   1                      synchronous, active-high; clears all state
//   flush      in   1                      synchronous; drops every buffered beat
//   in_data    in   N                      upstream data
//   in_valid   in   1                      upstream beat present
//   in_ready   out  1                      pipeline accepts beat (registered)
//   out_data   out  N                      downstream data
//   out_valid  out  1                      downstream beat present
//   out_ready  in   1                      downstream accepts beat
//   occupancy  out  $clog2(2*DEPTH+1)      beats currently held, 0..2*DEPTH
// BEHAVIOUR
//   - Transfer occurs on a posedge where valid&&ready on that side.
//   - Reset: all valid/skid flags 0; data and skid registers 0; out_valid=0;
//     out_data=0; occupancy=0.
//   - in_ready is 0 while reset is high and during the first cycle after release.
//     It is 1 from the second edge after release when empty.
//   - Stage k (0..DEPTH-1) state: main{valid,data}, skid{valid,data}, ready_r.
//   - Stage k ready_r <= !skid_valid_next; stage k upstream ready = ready_r.
//   - Main register loads when empty or when its beat leaves downstream this cycle.
//   - Otherwise an accepted beat goes to skid.
//   - Skid drains into main first, ahead of new input (order preserved).
//   - Latency: an accepted beat appears on out_valid DEPTH cycles later when
//     nothing is stalled. Throughput is 1 beat/cycle sustained.
//   - Capacity: exactly 2*DEPTH beats.
//   - At full, in_ready=0 and input is ignored even if in_valid=1.
//   - Beats exit strictly in acceptance order; no beat is duplicated or lost
//     except by flush or reset.
//   - occupancy <= occupancy + in_fire - out_fire. Simultaneous in/out at full or
//     at empty keeps the count consistent.
//   - flush: all valids cleared next edge; data registers keep their values.
//   - flush: a beat offered in the flush cycle is dropped; out_fire in the same
//     cycle still counts as delivered.
//   - flush: occupancy -> 0 and ready_r -> 1 next edge.
//   - reset has priority over flush.
//   - reset mid-stream discards all beats and obeys the reset values above.
//   - out_data is don't-care-stable: it holds its value while out_valid && !out_ready.
// STRUCTURE
//   - No shared package types needed.
//   - OCC_W = $clog2(2*DEPTH+1) is a localparam.
//   - One sub-module: register_skid_stage #(N) with clk, reset, flush,
//     in_*/out_* handshake.
//   - The top level generates DEPTH instances chained valid/ready and keeps the
//     occupancy counter.
// TESTING
//   1. Reset values: hold reset 3 cycles, release.
//      -> out_valid=0, out_data=0, occupancy=0 throughout reset.
//      -> in_ready=0 during reset and first post-release cycle, then 1.
//   2. Latency: DEPTH=3, out_ready=1, single beat 0xA5 at cycle t.
//      -> out_valid=1, out_data=0xA5 at cycle t+3 only; occupancy 1 for 3 cycles, then 0.
//   3. Backpressure: DEPTH=3, out_ready=0, offer 0x01..0x08 continuously.
//      -> 6 accepted, in_ready=0, occupancy=6.
//      -> raise out_ready: outputs 0x01..0x06 in order, then 0x07, 0x08.
//   4. Streaming: out_ready=1, 100 consecutive beats with random out_ready
//      toggling 50%. -> scoreboard order match, zero loss.
//      -> full 1 beat/cycle whenever out_ready=1 for long runs.
//   5. Flush: 4 beats buffered, assert flush with in_valid=1 (0xFF) and out_ready=0.
//      -> next cycle out_valid=0, occupancy=0, 0xFF never emerges, in_ready=1.
//   6. Reset mid-stream: 5 beats buffered, pulse reset 1 cycle.
//      -> no prior beat ever emerges; post-release beats flow with latency DEPTH.

Source files
------------

// File: rtl/register_pipeline_elastic_pkg.sv
// Shared defaults and sizing helper for the elastic register pipeline.
package register_pipeline_elastic_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_DEPTH = 2;

  // Width needed to count 0..2*depth buffered beats.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/register_skid_stage.sv
// One 2-entry skid buffer: main register plus skid register, with a registered
// upstream ready so no ready path runs combinationally through the stage.
module register_skid_stage
  import register_pipeline_elastic_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         r_main_valid;
  logic [N-1:0] r_main_data;
  logic         r_skid_valid;
  logic [N-1:0] r_skid_data;
  logic         r_ready;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;
  logic w_skid_valid_next;

  assign w_in_fire   = in_valid && r_ready;
  assign w_out_fire  = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_out_fire;

  // When main frees up, the skid entry moves into main, so skid stays
  // occupied only if a new beat lands behind it in the same cycle.
  always_comb begin
    w_skid_valid_next = r_skid_valid;
    if (w_main_free) begin
      w_skid_valid_next = r_skid_valid && w_in_fire;
    end else if (w_in_fire) begin
      w_skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready      <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_valid_next;
      r_ready      <= !w_skid_valid_next;
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
          if (w_in_fire) begin
            r_skid_data <= in_data;
          end
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_data  <= in_data;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

endmodule

// File: rtl/register_pipeline_elastic.sv
// DEPTH chained skid stages with flush and an occupancy counter.
// Handshake: a beat transfers on a posedge where valid && ready on that side.
module register_pipeline_elastic
  import register_pipeline_elastic_pkg::*;
#(
  parameter int  N     = DEF_N,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [N-1:0] w_data  [DEPTH+1];
  logic [DEPTH:0] w_valid;
  logic [DEPTH:0] w_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic [OCC_W-1:0] r_occ;

  assign w_data[0]      = in_data;
  assign w_valid[0]     = in_valid;
  assign w_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    register_skid_stage #(.N(N)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_data   (w_data[k]),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .out_data  (w_data[k+1]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1])
    );
  end

  assign w_in_fire  = in_valid && w_ready[0];
  assign w_out_fire = w_valid[DEPTH] && out_ready;

  // A beat delivered during flush still leaves; the count is zeroed regardless.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign in_ready  = w_ready[0];
  assign out_data  = w_data[DEPTH];
  assign out_valid = w_valid[DEPTH];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_register_pipeline_elastic.sv
// Self-checking bench for register_pipeline_elastic (DEPTH=3) with an
// acceptance-order scoreboard and directed latency/capacity/flush/reset checks.
module tb_register_pipeline_elastic;

  localparam int N     = 32;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(2 * DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  logic [N-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  register_pipeline_elastic #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [N-1:0] d);
    logic acc;
    int k;
    acc = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && k < 200) begin
      acc = in_ready;
      step();
      k++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((occupancy != 0 || exp_q.size() != 0) && k < 200) begin
      step();
      k++;
    end
    check(tag, 32'(occupancy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   nacc;
    logic [N-1:0] nxt;
    int   o0;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1. reset values
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end
    reset = 1'b0;
    check("rel_in_ready_first_cycle", 32'(in_ready), 32'd0);
    step();
    check("rel_in_ready_second", 32'(in_ready), 32'd1);

    // 2. latency DEPTH
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5;
    step();
    in_valid = 1'b0;
    check("lat_occ_t1", 32'(occupancy), 32'd1);
    check("lat_ov_t1", 32'(out_valid), 32'd0);
    step();
    check("lat_occ_t2", 32'(occupancy), 32'd1);
    check("lat_ov_t2", 32'(out_valid), 32'd0);
    step();
    check("lat_ov_t3", 32'(out_valid), 32'd1);
    check("lat_data_t3", out_data, 32'hA5);
    check("lat_occ_t3", 32'(occupancy), 32'd1);
    step();
    check("lat_ov_t4", 32'(out_valid), 32'd0);
    check("lat_occ_t4", 32'(occupancy), 32'd0);

    // 3. backpressure / capacity
    out_ready = 1'b0;
    nxt = 32'd1; nacc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = nxt;
      acc = in_ready;
      step();
      if (acc) begin nacc++; nxt++; end
    end
    check("bp_accepted", 32'(nacc), 32'd6);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_occupancy", 32'(occupancy), 32'd6);
    check("bp_head_valid", 32'(out_valid), 32'd1);
    check("bp_head_data", out_data, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && nxt <= 32'd8; i++) begin
      in_valid = 1'b1; in_data = nxt;
      acc = in_ready;
      step();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", nxt, 32'd9);
    drain("bp_drain");

    // 4. random streaming then sustained throughput
    nacc = 0;
    for (int i = 0; i < 2000 && nacc < 100; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      acc = in_ready;
      step();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    check("rnd_sent", 32'(nacc), 32'd100);
    drain("rnd_drain");
    out_ready = 1'b1;
    nacc = 0; o0 = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      acc = in_ready;
      step();
      if (i >= 10 && acc) nacc++;
      if (i == 9) o0 = n_out;
    end
    in_valid = 1'b0;
    check("tp_in_rate", 32'(nacc), 32'd40);
    check("tp_out_rate", 32'(n_out - o0), 32'd40);
    drain("tp_drain");

    // 5. flush
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(32'h10 + i);
    check("fl_occ_before", 32'(occupancy), 32'd4);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hFF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_occupancy", 32'(occupancy), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("fl_nothing_emerges", 32'(out_valid), 32'd0);
    end

    // 6. reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'h20 + i);
    check("mr_occ_before", 32'(occupancy), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_in_ready_first", 32'(in_ready), 32'd0);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_occupancy", 32'(occupancy), 32'd0);
    step();
    check("mr_in_ready_second", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h50;
    step();
    in_valid = 1'b0;
    step();
    check("mr_lat_ov_t2", 32'(out_valid), 32'd0);
    step();
    check("mr_lat_ov_t3", 32'(out_valid), 32'd1);
    check("mr_lat_data_t3", out_data, 32'h50);
    for (int i = 1; i < 5; i++) send_beat(32'h50 + i);
    drain("mr_drain");
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
